// File: rtl/eth_tx_arb_pkg.sv
// Types and helpers for the Ethernet TX source arbiter.
// Provides the arbiter state enum and the source-index width helper.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Index width for n sources; never narrower than one bit.
  function automatic int src_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packet_struct_pkg.sv
// Packet structure definitions shared by the Ethernet TX path.
// Provides the eth_hdr struct and its packed width ETH_HDR_W.
package packet_struct_pkg;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr;

  localparam int ETH_HDR_W = $bits(eth_hdr);

endpackage

// File: rtl/rr_arbiter_next.sv
// Combinational round-robin winner search.
// Ports:
//   req     - request vector, one bit per source
//   ptr     - highest-priority index (must be < N)
//   winner  - first requesting index found from ptr upward, wrapping
//   any_req - at least one request is asserted
module rr_arbiter_next #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  // Scan N positions starting at ptr; the first asserted request wins.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    winner  = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit keeps ptr + i from overflowing before the wrap.
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end else begin
        sum = sum;
      end
      idx = sum[IW-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end else begin
        any_req = any_req;
      end
    end
  end

endmodule

// File: rtl/eth_tx_src_arbiter.sv
// Round-robin arbiter sharing one eth_hdrtostream between NUM_SRCS producers.
// A grant is held from the header handshake through the last payload beat,
// so frames never interleave; one IDLE cycle separates consecutive frames.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   src_arb_* / arb_src_*       - per-source header and data channels
//   arb_dst_* / dst_arb_*       - muxed channels toward eth_hdrtostream
//   arb_grant_id                - granted source, meaningful outside IDLE
// Optional build macro ETH_TX_SRC_ARBITER_STATS_EN adds:
//   arb_frame_cnt  - per-source completed-frame counters (wrapping)
//   arb_stall_cnt  - cycles in HDR/DATA with downstream not ready (saturating)
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef PKT_TIMESTAMP_W
`define PKT_TIMESTAMP_W 64
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

module eth_tx_src_arbiter
  import packet_struct_pkg::*;
  import eth_tx_arb_pkg::*;
#(
  parameter  int NUM_SRCS = 2,
  localparam int SRC_ID_W = src_id_w(NUM_SRCS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SRCS-1:0]                   src_arb_eth_hdr_val,
  input  logic [NUM_SRCS*ETH_HDR_W-1:0]         src_arb_eth_hdr,
  input  logic [NUM_SRCS*`MTU_SIZE_W-1:0]       src_arb_payload_len,
  input  logic [NUM_SRCS*`PKT_TIMESTAMP_W-1:0]  src_arb_timestamp,
  output logic [NUM_SRCS-1:0]                   arb_src_eth_hdr_rdy,
  input  logic [NUM_SRCS-1:0]                   src_arb_data_val,
  input  logic [NUM_SRCS*`MAC_INTERFACE_W-1:0]  src_arb_data,
  input  logic [NUM_SRCS-1:0]                   src_arb_data_last,
  input  logic [NUM_SRCS*`MAC_PADBYTES_W-1:0]   src_arb_data_padbytes,
  output logic [NUM_SRCS-1:0]                   arb_src_data_rdy,
  output logic                                  arb_dst_eth_hdr_val,
  output logic [ETH_HDR_W-1:0]                  arb_dst_eth_hdr,
  output logic [`MTU_SIZE_W-1:0]                arb_dst_payload_len,
  output logic [`PKT_TIMESTAMP_W-1:0]           arb_dst_timestamp,
  input  logic                                  dst_arb_eth_hdr_rdy,
  output logic                                  arb_dst_data_val,
  output logic [`MAC_INTERFACE_W-1:0]           arb_dst_data,
  output logic                                  arb_dst_data_last,
  output logic [`MAC_PADBYTES_W-1:0]            arb_dst_data_padbytes,
  input  logic                                  dst_arb_data_rdy,
  output logic [SRC_ID_W-1:0]                   arb_grant_id
`ifdef ETH_TX_SRC_ARBITER_STATS_EN
  ,
  output logic [NUM_SRCS*32-1:0]                arb_frame_cnt,
  output logic [31:0]                           arb_stall_cnt
`endif
);

  arb_state_e          state_reg, state_next;
  logic [SRC_ID_W-1:0] grant_reg, grant_next;
  logic [SRC_ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [SRC_ID_W-1:0] winner;
  logic                any_req;
  logic                frame_done;

  rr_arbiter_next #(
    .N  (NUM_SRCS),
    .IW (SRC_ID_W)
  ) u_rr_next (
    .req     (src_arb_eth_hdr_val),
    .ptr     (rr_ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Next-state logic and the val/rdy steering for the granted source.
  always_comb begin
    state_next          = state_reg;
    grant_next          = grant_reg;
    rr_ptr_next         = rr_ptr_reg;
    arb_src_eth_hdr_rdy = '0;
    arb_src_data_rdy    = '0;
    arb_dst_eth_hdr_val = 1'b0;
    arb_dst_data_val    = 1'b0;
    frame_done          = 1'b0;
    case (state_reg)
      IDLE: begin
        // Arbitration bubble: pick a winner, no handshake this cycle.
        if (any_req) begin
          grant_next = winner;
          state_next = HDR;
        end else begin
          state_next = IDLE;
        end
      end
      HDR: begin
        arb_dst_eth_hdr_val            = src_arb_eth_hdr_val[grant_reg];
        arb_src_eth_hdr_rdy[grant_reg] = dst_arb_eth_hdr_rdy;
        if (src_arb_eth_hdr_val[grant_reg] && dst_arb_eth_hdr_rdy) begin
          state_next = DATA;
        end else begin
          state_next = HDR;
        end
      end
      DATA: begin
        arb_dst_data_val            = src_arb_data_val[grant_reg];
        arb_src_data_rdy[grant_reg] = dst_arb_data_rdy;
        if (src_arb_data_val[grant_reg] && dst_arb_data_rdy &&
            src_arb_data_last[grant_reg]) begin
          frame_done = 1'b1;
          state_next = IDLE;
          // The source just served gets lowest priority next time.
          if (grant_reg == SRC_ID_W'(NUM_SRCS-1)) begin
            rr_ptr_next = '0;
          end else begin
            rr_ptr_next = grant_reg + SRC_ID_W'(1);
          end
        end else begin
          state_next = DATA;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Payload fields follow the grant; they are only meaningful with their val.
  assign arb_dst_eth_hdr       = src_arb_eth_hdr[int'(grant_reg)*ETH_HDR_W +: ETH_HDR_W];
  assign arb_dst_payload_len   = src_arb_payload_len[int'(grant_reg)*`MTU_SIZE_W +: `MTU_SIZE_W];
  assign arb_dst_timestamp     = src_arb_timestamp[int'(grant_reg)*`PKT_TIMESTAMP_W +: `PKT_TIMESTAMP_W];
  assign arb_dst_data          = src_arb_data[int'(grant_reg)*`MAC_INTERFACE_W +: `MAC_INTERFACE_W];
  assign arb_dst_data_last     = src_arb_data_last[grant_reg];
  assign arb_dst_data_padbytes = src_arb_data_padbytes[int'(grant_reg)*`MAC_PADBYTES_W +: `MAC_PADBYTES_W];
  assign arb_grant_id          = grant_reg;

`ifdef ETH_TX_SRC_ARBITER_STATS_EN
  logic [31:0] frame_cnt_reg [NUM_SRCS];
  logic [31:0] stall_cnt_reg;
  logic        stall;

  assign stall = ((state_reg == HDR)  && !dst_arb_eth_hdr_rdy) ||
                 ((state_reg == DATA) && !dst_arb_data_rdy);

  // Per-source frame counters (wrapping) and the saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRCS; i++) begin
        frame_cnt_reg[i] <= 32'd0;
      end
      stall_cnt_reg <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_SRCS; i++) begin
        if (frame_done && (grant_reg == SRC_ID_W'(i))) begin
          frame_cnt_reg[i] <= frame_cnt_reg[i] + 32'd1;
        end else begin
          frame_cnt_reg[i] <= frame_cnt_reg[i];
        end
      end
      if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end else begin
        stall_cnt_reg <= stall_cnt_reg;
      end
    end
  end

  // Flatten the per-source counters onto the output bus.
  always_comb begin
    arb_frame_cnt = '0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      arb_frame_cnt[i*32 +: 32] = frame_cnt_reg[i];
    end
  end

  assign arb_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_eth_tx_src_arbiter.sv
// Directed self-checking bench for eth_tx_src_arbiter.
// Instance a: NUM_SRCS = 2; instance b: NUM_SRCS = 3.
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef PKT_TIMESTAMP_W
`define PKT_TIMESTAMP_W 64
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

module tb_eth_tx_src_arbiter;
  import packet_struct_pkg::*;

  localparam int HW = ETH_HDR_W;
  localparam int LW = `MTU_SIZE_W;
  localparam int TW = `PKT_TIMESTAMP_W;
  localparam int DW = `MAC_INTERFACE_W;
  localparam int PW = `MAC_PADBYTES_W;

  localparam logic [HW-1:0] H0  = 112'h0a0b0c0d0e0f_010203040506_0800;
  localparam logic [HW-1:0] H1  = 112'h1a1b1c1d1e1f_111213141516_0806;
  localparam logic [HW-1:0] HB0 = 112'h2a2b2c2d2e2f_212223242526_0800;
  localparam logic [HW-1:0] HB2 = 112'h3a3b3c3d3e3f_313233343536_0806;
  localparam logic [TW-1:0] TS0 = 64'h0000_1234_5678_9abc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a signals
  logic [1:0]      a_hv, a_hrdy, a_dv, a_dl, a_drdy;
  logic [2*HW-1:0] a_hdr;
  logic [2*LW-1:0] a_len;
  logic [2*TW-1:0] a_ts;
  logic [2*DW-1:0] a_dat;
  logic [2*PW-1:0] a_pb;
  logic            a_dst_hval, a_dst_hrdy, a_dst_dval, a_dst_drdy, a_dst_last;
  logic [HW-1:0]   a_dst_hdr;
  logic [LW-1:0]   a_dst_len;
  logic [TW-1:0]   a_dst_ts;
  logic [DW-1:0]   a_dst_dat;
  logic [PW-1:0]   a_dst_pb;
  logic [0:0]      a_grant;

  // Instance b signals
  logic [2:0]      b_hv, b_hrdy, b_dv, b_dl, b_drdy;
  logic [3*HW-1:0] b_hdr;
  logic [3*LW-1:0] b_len;
  logic [3*TW-1:0] b_ts;
  logic [3*DW-1:0] b_dat;
  logic [3*PW-1:0] b_pb;
  logic            b_dst_hval, b_dst_hrdy, b_dst_dval, b_dst_drdy, b_dst_last;
  logic [HW-1:0]   b_dst_hdr;
  logic [LW-1:0]   b_dst_len;
  logic [TW-1:0]   b_dst_ts;
  logic [DW-1:0]   b_dst_dat;
  logic [PW-1:0]   b_dst_pb;
  logic [1:0]      b_grant;

`ifdef ETH_TX_SRC_ARBITER_STATS_EN
  logic [2*32-1:0] a_frame_cnt;
  logic [31:0]     a_stall_cnt;
  logic [3*32-1:0] b_frame_cnt;
  logic [31:0]     b_stall_cnt;
`endif

  eth_tx_src_arbiter #(.NUM_SRCS(2)) dut_a (
    .clk(clk), .rst(rst),
    .src_arb_eth_hdr_val(a_hv), .src_arb_eth_hdr(a_hdr),
    .src_arb_payload_len(a_len), .src_arb_timestamp(a_ts),
    .arb_src_eth_hdr_rdy(a_hrdy),
    .src_arb_data_val(a_dv), .src_arb_data(a_dat),
    .src_arb_data_last(a_dl), .src_arb_data_padbytes(a_pb),
    .arb_src_data_rdy(a_drdy),
    .arb_dst_eth_hdr_val(a_dst_hval), .arb_dst_eth_hdr(a_dst_hdr),
    .arb_dst_payload_len(a_dst_len), .arb_dst_timestamp(a_dst_ts),
    .dst_arb_eth_hdr_rdy(a_dst_hrdy),
    .arb_dst_data_val(a_dst_dval), .arb_dst_data(a_dst_dat),
    .arb_dst_data_last(a_dst_last), .arb_dst_data_padbytes(a_dst_pb),
    .dst_arb_data_rdy(a_dst_drdy),
    .arb_grant_id(a_grant)
`ifdef ETH_TX_SRC_ARBITER_STATS_EN
    , .arb_frame_cnt(a_frame_cnt), .arb_stall_cnt(a_stall_cnt)
`endif
  );

  eth_tx_src_arbiter #(.NUM_SRCS(3)) dut_b (
    .clk(clk), .rst(rst),
    .src_arb_eth_hdr_val(b_hv), .src_arb_eth_hdr(b_hdr),
    .src_arb_payload_len(b_len), .src_arb_timestamp(b_ts),
    .arb_src_eth_hdr_rdy(b_hrdy),
    .src_arb_data_val(b_dv), .src_arb_data(b_dat),
    .src_arb_data_last(b_dl), .src_arb_data_padbytes(b_pb),
    .arb_src_data_rdy(b_drdy),
    .arb_dst_eth_hdr_val(b_dst_hval), .arb_dst_eth_hdr(b_dst_hdr),
    .arb_dst_payload_len(b_dst_len), .arb_dst_timestamp(b_dst_ts),
    .dst_arb_eth_hdr_rdy(b_dst_hrdy),
    .arb_dst_data_val(b_dst_dval), .arb_dst_data(b_dst_dat),
    .arb_dst_data_last(b_dst_last), .arb_dst_data_padbytes(b_dst_pb),
    .dst_arb_data_rdy(b_dst_drdy),
    .arb_grant_id(b_grant)
`ifdef ETH_TX_SRC_ARBITER_STATS_EN
    , .arb_frame_cnt(b_frame_cnt), .arb_stall_cnt(b_stall_cnt)
`endif
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b;
    int ex;
    rst = 1'b1;
    a_hv = '0; a_hdr = '0; a_len = '0; a_ts = '0; a_dv = '0; a_dat = '0; a_dl = '0; a_pb = '0;
    b_hv = '0; b_hdr = '0; b_len = '0; b_ts = '0; b_dv = '0; b_dat = '0; b_dl = '0; b_pb = '0;
    a_dst_hrdy = 1'b1; a_dst_drdy = 1'b1;
    b_dst_hrdy = 1'b1; b_dst_drdy = 1'b1;

    // Reset state
    tick(); #1;
    chk("rst_hval", a_dst_hval, 1'b0);
    chk("rst_dval", a_dst_dval, 1'b0);
    chk("rst_hrdy", a_hrdy, 2'b00);
    chk("rst_drdy", a_drdy, 2'b00);
    chk("rst_grant", a_grant, 1'b0);
    chk("rst_b_grant", b_grant, 2'd0);
    tick(); rst = 1'b0;

    // Test 1: single source 0, 3-beat frame
    tick(); a_hv = 2'b01; a_hdr[0 +: HW] = H0; a_len[0 +: LW] = 16'd1500; a_ts[0 +: TW] = TS0; #1;
    chk("t1_idle_hval", a_dst_hval, 1'b0);
    chk("t1_idle_hrdy", a_hrdy, 2'b00);
    tick(); #1;
    chk("t1_hval", a_dst_hval, 1'b1);
    chk("t1_hdr", a_dst_hdr, H0);
    chk("t1_len", a_dst_len, 16'd1500);
    chk("t1_ts", a_dst_ts, TS0);
    chk("t1_hrdy", a_hrdy, 2'b01);
    chk("t1_grant", a_grant, 1'b0);
    tick(); a_hv = 2'b00; a_dv = 2'b01; a_dat[0 +: DW] = 64'hD000_0000_0000_0001; a_dl = 2'b00; #1;
    chk("t1_b1_val", a_dst_dval, 1'b1);
    chk("t1_b1_dat", a_dst_dat, 64'hD000_0000_0000_0001);
    chk("t1_b1_rdy", a_drdy, 2'b01);
    chk("t1_b1_hval", a_dst_hval, 1'b0);
    tick(); a_dat[0 +: DW] = 64'hD000_0000_0000_0002; #1;
    chk("t1_b2_dat", a_dst_dat, 64'hD000_0000_0000_0002);
    chk("t1_b2_last", a_dst_last, 1'b0);
    tick(); a_dat[0 +: DW] = 64'hD000_0000_0000_0003; a_dl = 2'b01; a_pb[0 +: PW] = 3'd5; #1;
    chk("t1_b3_dat", a_dst_dat, 64'hD000_0000_0000_0003);
    chk("t1_b3_last", a_dst_last, 1'b1);
    chk("t1_b3_pb", a_dst_pb, 3'd5);
    tick(); a_dv = 2'b00; a_dl = 2'b00; #1;
    chk("t1_end_dval", a_dst_dval, 1'b0);
    chk("t1_end_drdy", a_drdy, 2'b00);

    // Test 2: both request from reset; 0 first, then 1 after a gap
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; a_hv = 2'b11; a_hdr[HW +: HW] = H1; #1;
    chk("t2_idle_hrdy", a_hrdy, 2'b00);
    tick(); #1;
    chk("t2_grant0", a_grant, 1'b0);
    chk("t2_hrdy0", a_hrdy, 2'b01);
    chk("t2_hdr0", a_dst_hdr, H0);
    tick(); a_hv = 2'b10; a_dv = 2'b01; a_dat[0 +: DW] = 64'hD000_0000_0000_0004; a_dl = 2'b01; #1;
    chk("t2_d0_last", a_dst_last, 1'b1);
    chk("t2_d0_hrdy", a_hrdy, 2'b00);
    chk("t2_d0_drdy", a_drdy, 2'b01);
    tick(); a_dv = 2'b00; a_dl = 2'b00; #1;
    chk("t2_gap_hval", a_dst_hval, 1'b0);
    chk("t2_gap_hrdy", a_hrdy, 2'b00);
    tick(); #1;
    chk("t2_grant1", a_grant, 1'b1);
    chk("t2_hrdy1", a_hrdy, 2'b10);
    chk("t2_hdr1", a_dst_hdr, H1);
    tick(); a_hv = 2'b00; a_dv = 2'b10; a_dat[DW +: DW] = 64'hD000_0000_0000_0005; a_dl = 2'b10; #1;
    chk("t2_d1_dat", a_dst_dat, 64'hD000_0000_0000_0005);
    chk("t2_d1_drdy", a_drdy, 2'b10);

    // Test 3: both keep requesting; grants alternate 0,1,0,1
    for (int f = 0; f < 4; f++) begin
      ex = f % 2;
      tick(); a_dv = 2'b00; a_dl = 2'b00; a_hv = 2'b11; #1;
      chk("t3_idle_hval", a_dst_hval, 1'b0);
      tick(); #1;
      chk("t3_grant", a_grant, ex);
      chk("t3_hrdy", a_hrdy, (ex == 1) ? 2'b10 : 2'b01);
      tick(); a_dv = (ex == 1) ? 2'b10 : 2'b01; a_dl = a_dv;
      a_dat[ex*DW +: DW] = 64'hF000_0000_0000_0000 + 64'(f); #1;
      chk("t3_drdy", a_drdy, a_dv);
      chk("t3_dat", a_dst_dat, 64'hF000_0000_0000_0000 + 64'(f));
    end

    // Test 4: 4-beat frame from source 0 with data rdy toggling
    tick(); a_dv = 2'b00; a_dl = 2'b00; a_hv = 2'b01; #1;
    chk("t4_idle_hval", a_dst_hval, 1'b0);
    tick(); #1;
    chk("t4_hval", a_dst_hval, 1'b1);
    chk("t4_grant", a_grant, 1'b0);
    b = 0;
    for (int c = 0; c < 8; c++) begin
      tick(); a_hv = 2'b00; a_dst_drdy = (c % 2 == 1) ? 1'b1 : 1'b0;
      a_dv = 2'b01; a_dat[0 +: DW] = 64'hB000_0000_0000_0000 + 64'(b);
      a_dl = (b == 3) ? 2'b01 : 2'b00; #1;
      chk("t4_dval", a_dst_dval, 1'b1);
      chk("t4_dat", a_dst_dat, 64'hB000_0000_0000_0000 + 64'(b));
      chk("t4_drdy", a_drdy, {1'b0, a_dst_drdy});
      if (a_dst_drdy) b++;
    end
    tick(); a_dv = 2'b00; a_dl = 2'b00; a_dst_drdy = 1'b1; #1;
    chk("t4_end_dval", a_dst_dval, 1'b0);
`ifdef ETH_TX_SRC_ARBITER_STATS_EN
    chk("t4_stall_cnt", a_stall_cnt, 32'd4);
    chk("t4_frame_cnt", a_frame_cnt, {32'd3, 32'd4});
`endif

    // Test 5: reset during beat 2 of a 5-beat frame
    tick(); a_hv = 2'b01; #1;
    chk("t5_idle_hval", a_dst_hval, 1'b0);
    tick(); #1;
    chk("t5_grant", a_grant, 1'b0);
    tick(); a_hv = 2'b00; a_dv = 2'b01; a_dat[0 +: DW] = 64'hE000_0000_0000_0001; a_dl = 2'b00; #1;
    chk("t5_b1_dat", a_dst_dat, 64'hE000_0000_0000_0001);
    tick(); a_dat[0 +: DW] = 64'hE000_0000_0000_0002; rst = 1'b1; #1;
    chk("t5_rst_hrdy", a_hrdy, 2'b00);
    chk("t5_rst_drdy", a_drdy, 2'b00);
    chk("t5_rst_hval", a_dst_hval, 1'b0);
    chk("t5_rst_dval", a_dst_dval, 1'b0);
    tick(); rst = 1'b0; a_dv = 2'b00; a_hv = 2'b11; #1;
    chk("t5_post_hval", a_dst_hval, 1'b0);
    tick(); #1;
    chk("t5_post_grant", a_grant, 1'b0);
    chk("t5_post_hrdy", a_hrdy, 2'b01);
    a_hv = 2'b00;

    // Test 6: NUM_SRCS=3, rr_ptr moved to 1, sources 0 and 2 request
    tick(); b_hv = 3'b001; b_hdr[0 +: HW] = HB0; b_hdr[2*HW +: HW] = HB2; #1;
    chk("t6_idle_hval", b_dst_hval, 1'b0);
    tick(); #1;
    chk("t6_pre_grant", b_grant, 2'd0);
    chk("t6_pre_hrdy", b_hrdy, 3'b001);
    tick(); b_hv = 3'b000; b_dv = 3'b001; b_dl = 3'b001; b_dat[0 +: DW] = 64'hC000_0000_0000_0000; #1;
    chk("t6_pre_drdy", b_drdy, 3'b001);
    chk("t6_pre_dat", b_dst_dat, 64'hC000_0000_0000_0000);
    tick(); b_dv = 3'b000; b_dl = 3'b000; b_hv = 3'b101; #1;
    chk("t6_idle_hrdy", b_hrdy, 3'b000);
    tick(); #1;
    chk("t6_grant2", b_grant, 2'd2);
    chk("t6_hrdy2", b_hrdy, 3'b100);
    chk("t6_hdr2", b_dst_hdr, HB2);
    tick(); b_hv = 3'b001; b_dv = 3'b100; b_dl = 3'b100; b_dat[2*DW +: DW] = 64'hC000_0000_0000_0002; #1;
    chk("t6_drdy2", b_drdy, 3'b100);
    chk("t6_dat2", b_dst_dat, 64'hC000_0000_0000_0002);
    tick(); b_dv = 3'b000; b_dl = 3'b000; #1;
    chk("t6_gap_hval", b_dst_hval, 1'b0);
    tick(); #1;
    chk("t6_grant0", b_grant, 2'd0);
    chk("t6_hrdy0", b_hrdy, 3'b001);
    chk("t6_hdr0", b_dst_hdr, HB0);
    tick(); b_hv = 3'b000; b_dv = 3'b001; b_dl = 3'b001; #1;
    chk("t6_drdy0", b_drdy, 3'b001);
    tick(); b_dv = 3'b000; b_dl = 3'b000; #1;
    chk("t6_end_dval", b_dst_dval, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
